fifo_access_arbiter: RTL
========================

Name: fifo_access_arbiter

Overview:
Sequences the asymmetric FIFO formed by the team's FIFO controller and its register file. The FIFO takes 16-bit words on the write side and returns 8-bit bytes on the read side.
- Write side: shares the single FIFO write port between two 16-bit producers using round-robin arbitration with a burst cap.
- Read side: drains the FIFO one byte at a time into a one-entry output register with a valid/ready handshake.
- Placement: sits between the producers/consumer and the FIFO controller's wr/rd/full/empty interface.

Parameters:
W_WIDTH, 16, write word width; must equal 2*R_WIDTH.
R_WIDTH, 8, read byte width.
BURST_MAX, 4, max consecutive grants to one requester while the other is requesting (range 1..15).

Ports:
clk  in  1  system clock, all logic on rising edge
reset_n  in  1  asynchronous active-low reset
req  in  2  per-producer write request, level, held until granted
wdata0  in  W_WIDTH  producer 0 word, stable while req[0]
wdata1  in  W_WIDTH  producer 1 word, stable while req[1]
gnt  out  2  one-hot grant; gnt[i]=1 means word i is written this cycle
fifo_wr  out  1  FIFO write strobe
fifo_wdata  out  W_WIDTH  word to FIFO
fifo_full  in  1  FIFO full flag
fifo_empty  in  1  FIFO empty flag
fifo_rd  out  1  FIFO read (pop) strobe
fifo_rdata  in  R_WIDTH  FIFO head byte (combinational from FIFO)
rd_valid  out  1  output byte valid
rd_ready  in  1  consumer accepts byte
rd_data  out  R_WIDTH  output byte
rd_hi  out  1  1 = rd_data is bits [15:8] of its word

Behaviour:
Reset (reset_n=0, async): all outputs 0. Round-robin pointer selects producer 0 first. Burst counter 0. Read FSM in EMPTY. Any held output byte is discarded. Release takes effect on the first clk edge with reset_n=1.

Write arbitration (combinational grant from registered state):
- gnt = 0 whenever fifo_full=1 or req=0.
- Only one requester active: grant it.
- Both requesting: grant the pointer holder, unless its burst count equals BURST_MAX; then grant the other.
- fifo_wr = |gnt. fifo_wdata = word of the granted producer (0 when idle). Zero latency: the word is written in the gnt cycle.
- On every grant, the pointer moves to the non-granted producer.
- Burst counter: increments when the same producer is granted again with the other requesting; resets to 1 on a producer change; resets to 0 when the other producer is not requesting.

Read FSM, states EMPTY and LOADED:
- EMPTY: if fifo_empty=0, assert fifo_rd, load rd_data <= fifo_rdata, go to LOADED. rd_valid=0.
- LOADED: rd_valid=1.
  - If rd_ready=1 and fifo_empty=0: assert fifo_rd, reload rd_data, stay in LOADED. This gives back-to-back, 1 byte/cycle.
  - If rd_ready=1 and fifo_empty=1: go to EMPTY.
  - If rd_ready=0: hold rd_data and rd_valid; fifo_rd=0.
- Latency: a byte reaches rd_data 1 cycle after fifo_empty falls.

rd_hi:
- Even FIFO address holds bits [15:8].
- rd_hi is a registered toggle, initialised to 1 on reset. It is captured with each load and flips after each pop.

Boundaries:
- The FIFO ignores both strobes when full with wr=rd=1. The arbiter never asserts fifo_wr when fifo_full=1, so reads always progress when full.
- fifo_rd is never asserted when fifo_empty=1. Write-side requests are never lost: req stays high until gnt.
- Pointer and toggle wrap naturally modulo 2.

Decomposition:
- Package fifo_arb_pkg:
  - typedef rd_state_t {EMPTY, LOADED}
  - localparam NUM_REQ=2
  - W_WIDTH/R_WIDTH defaults
- Sub-module rr_arbiter2: pointer, burst counter, grant logic. Instantiated once.
- Read FSM and output register stay in the top level.

Test Plan:
1. Reset with req=2'b11, fifo_full=0, wdata0=16'hA1A2, wdata1=16'hB1B2 -> gnt sequence 01,10,01,10; fifo_wdata alternates A1A2/B1B2; fifo_wr=1 every cycle.
2. BURST_MAX=2; req=01 for 3 cycles, then 11 -> producer 0 gets at most 2 consecutive grants after req[1] rises, then gnt=10.
3. fifo_full=1 with req=11 for 5 cycles -> gnt=0, fifo_wr=0 throughout; full falls -> grant issued the same cycle.
4. FIFO holds word 16'h1234, rd_ready=1 -> rd_data 8'h12 with rd_hi=1, then 8'h34 with rd_hi=0 on consecutive cycles; fifo_rd pulses twice; FSM returns to EMPTY.
5. rd_ready=0 while LOADED for 4 cycles -> rd_data stable, fifo_rd=0; rd_ready=1 -> next byte appears the following cycle.
6. reset_n asserted mid-stream while LOADED, then released -> rd_valid=0 immediately, gnt=0; the first grant after release goes to producer 0.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types and defaults for the asymmetric FIFO access arbiter.
package fifo_arb_pkg;

    localparam int unsigned NUM_REQ      = 2;
    localparam int unsigned W_WIDTH_DFLT = 16;
    localparam int unsigned R_WIDTH_DFLT = 8;

    typedef enum logic {
        EMPTY  = 1'b0,
        LOADED = 1'b1
    } rd_state_t;

endpackage

// File: rtl/fifo_access_arbiter_if.sv
// Producer, FIFO-controller and consumer signals of the FIFO access arbiter.
// master: the arbiter's view; slave: the surrounding producers/FIFO/consumer.
interface fifo_access_arbiter_if
    import fifo_arb_pkg::*;
#(
    parameter int unsigned W_WIDTH = W_WIDTH_DFLT,
    parameter int unsigned R_WIDTH = R_WIDTH_DFLT
) ();

    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] gnt;
    logic [W_WIDTH-1:0] wdata0;
    logic [W_WIDTH-1:0] wdata1;
    logic               fifo_wr;
    logic [W_WIDTH-1:0] fifo_wdata;
    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_rd;
    logic [R_WIDTH-1:0] fifo_rdata;
    logic               rd_valid;
    logic               rd_ready;
    logic [R_WIDTH-1:0] rd_data;
    logic               rd_hi;

    modport master (
        input  req, wdata0, wdata1, fifo_full, fifo_empty, fifo_rdata, rd_ready,
        output gnt, fifo_wr, fifo_wdata, fifo_rd, rd_valid, rd_data, rd_hi
    );

    modport slave (
        output req, wdata0, wdata1, fifo_full, fifo_empty, fifo_rdata, rd_ready,
        input  gnt, fifo_wr, fifo_wdata, fifo_rd, rd_valid, rd_data, rd_hi
    );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter with a burst cap. Grant is combinational
// from registered pointer/burst state; it is suppressed while the FIFO is full.
module rr_arbiter2
    import fifo_arb_pkg::*;
#(
    parameter int unsigned BURST_MAX = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               i_en,
    input  logic [NUM_REQ-1:0] i_req,
    input  logic               i_full,
    output logic [NUM_REQ-1:0] o_gnt
);

    logic       r_ptr;
    logic       r_last;
    logic [3:0] r_cnt;

    logic [NUM_REQ-1:0] w_gnt;
    logic [3:0]         w_hold_cnt;
    logic               w_id;

    // Grant selection: single requester wins outright; with both requesting
    // the pointer holder wins unless it has used up its burst allowance.
    always_comb begin
        w_gnt      = '0;
        w_hold_cnt = (r_last == r_ptr) ? r_cnt : '0;
        if (i_en && !i_full) begin
            case (i_req)
                2'b01:   w_gnt = 2'b01;
                2'b10:   w_gnt = 2'b10;
                2'b11: begin
                    if (w_hold_cnt == 4'(BURST_MAX))
                        w_gnt = r_ptr ? 2'b01 : 2'b10;
                    else
                        w_gnt = r_ptr ? 2'b10 : 2'b01;
                end
                default: w_gnt = '0;
            endcase
        end
        w_id = w_gnt[1];
    end

    assign o_gnt = w_gnt;

    // Pointer hands priority to the loser; burst counter tracks repeat grants
    // only while the other producer is competing.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr  <= 1'b0;
            r_last <= 1'b0;
            r_cnt  <= '0;
        end else if (w_gnt != '0) begin
            r_ptr  <= ~w_id;
            r_last <= w_id;
            if (i_req[~w_id])
                r_cnt <= (w_id == r_last) ? ((r_cnt == 4'hF) ? r_cnt : r_cnt + 4'd1) : 4'd1;
            else
                r_cnt <= '0;
        end
    end

endmodule

// File: rtl/fifo_access_arbiter.sv
// Write-side arbitration and read-side byte drain for the 16-in / 8-out FIFO.
module fifo_access_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned W_WIDTH   = W_WIDTH_DFLT,
    parameter int unsigned R_WIDTH   = R_WIDTH_DFLT,
    parameter int unsigned BURST_MAX = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    fifo_access_arbiter_if.master  bus
);

    rd_state_t          r_state;
    logic               r_active;
    logic               r_valid;
    logic [R_WIDTH-1:0] r_data;
    logic               r_hi;
    logic               r_tog;

    logic [NUM_REQ-1:0] w_gnt;
    logic [W_WIDTH-1:0] w_wdata;
    logic               w_pop;

    rr_arbiter2 #(
        .BURST_MAX (BURST_MAX)
    ) u_rr (
        .clk     (clk),
        .reset_n (reset_n),
        .i_en    (r_active),
        .i_req   (bus.req),
        .i_full  (bus.fifo_full),
        .o_gnt   (w_gnt)
    );

    // Write path: granted word goes to the FIFO in the grant cycle.
    always_comb begin
        w_wdata = '0;
        if (w_gnt[1])
            w_wdata = bus.wdata1;
        else if (w_gnt[0])
            w_wdata = bus.wdata0;
    end

    assign bus.gnt        = w_gnt;
    assign bus.fifo_wr    = |w_gnt;
    assign bus.fifo_wdata = w_wdata;

    // Pop whenever the output register is free or being drained this cycle.
    assign w_pop       = r_active && !bus.fifo_empty && ((r_state == EMPTY) || bus.rd_ready);
    assign bus.fifo_rd = w_pop;

    // Holds everything off until the first clock edge after reset release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_active <= 1'b0;
        else
            r_active <= 1'b1;
    end

    // Read FSM with one-entry output register and half-word toggle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= EMPTY;
            r_valid <= 1'b0;
            r_data  <= '0;
            r_hi    <= 1'b0;
            r_tog   <= 1'b1;
        end else if (w_pop) begin
            r_state <= LOADED;
            r_valid <= 1'b1;
            r_data  <= bus.fifo_rdata;
            r_hi    <= r_tog;
            r_tog   <= ~r_tog;
        end else if ((r_state == LOADED) && bus.rd_ready) begin
            r_state <= EMPTY;
            r_valid <= 1'b0;
        end
    end

    assign bus.rd_valid = r_valid;
    assign bus.rd_data  = r_data;
    assign bus.rd_hi    = r_hi;

endmodule
